// File: rtl/decoder_4_16.sv
// 4-to-16 one-hot decoder with registered copy, last-index and valid flops.
// Optional sticky seen-mask enabled by defining DECODER_4_16_SEEN_MASK_EN.
module decoder_4_16 #(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  in,
    output logic [15:0] out,
    output logic [15:0] out_q,
    output logic [3:0]  idx_q,
    output logic        valid_q,
    output logic [15:0] seen_q
);

    localparam logic [15:0] INACTIVE = ACTIVE_LOW ? 16'hFFFF : 16'h0000;

    logic [15:0] onehot;
    logic [15:0] out_d;
    logic [3:0]  idx_d;
    logic        valid_d;

    // Active-high one-hot of the input code, all-zero when disabled.
    always_comb begin
        onehot = 16'h0000;
        if (en) begin
            onehot = 16'h0001 << in;
        end
    end

    assign out = ACTIVE_LOW ? ~onehot : onehot;

    // Next-state for the registered outputs; idx holds while disabled.
    always_comb begin
        out_d   = out;
        valid_d = en;
        idx_d   = idx_q;
        if (en) begin
            idx_d = in;
        end
    end

    // Registered outputs; reset wins over en and in.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= INACTIVE;
            valid_q <= 1'b0;
            idx_q   <= 4'h0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
        end
    end

`ifdef DECODER_4_16_SEEN_MASK_EN
    logic [15:0] seen_d;

    // Accumulate every decoded code; always active-high.
    always_comb begin
        seen_d = seen_q | onehot;
    end

    // Sticky mask register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            seen_q <= 16'h0000;
        end else begin
            seen_q <= seen_d;
        end
    end
`else
    assign seen_q = 16'h0000;
`endif

endmodule

// File: tb/tb_decoder_4_16.sv
// Directed bench for decoder_4_16, both output polarities side by side.
// Seen-mask expectations follow DECODER_4_16_SEEN_MASK_EN.
module tb_decoder_4_16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [3:0]  in  = 4'h0;

    logic [15:0] out0, out_q0, seen_q0;
    logic [3:0]  idx_q0;
    logic        valid_q0;
    logic [15:0] out1, out_q1, seen_q1;
    logic [3:0]  idx_q1;
    logic        valid_q1;

    int pass_cnt = 0;
    int total    = 0;

    decoder_4_16 #(.ACTIVE_LOW(1'b0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .in(in),
        .out(out0), .out_q(out_q0), .idx_q(idx_q0),
        .valid_q(valid_q0), .seen_q(seen_q0)
    );

    decoder_4_16 #(.ACTIVE_LOW(1'b1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .in(in),
        .out(out1), .out_q(out_q1), .idx_q(idx_q1),
        .valid_q(valid_q1), .seen_q(seen_q1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

`ifdef DECODER_4_16_SEEN_MASK_EN
    localparam logic [15:0] SWEEP_SEEN = 16'hFFFF;
    localparam logic [15:0] MASK_SEEN  = 16'h8012;
`else
    localparam logic [15:0] SWEEP_SEEN = 16'h0000;
    localparam logic [15:0] MASK_SEEN  = 16'h0000;
`endif

    initial begin
        logic [15:0] exp;

        // Reset state
        tick();
        tick();
        chk("rst_out_q0",   out_q0, 16'h0000);
        chk("rst_out_q1",   out_q1, 16'hFFFF);
        chk("rst_valid",    {15'd0, valid_q0}, 16'h0000);
        chk("rst_idx",      {12'd0, idx_q0}, 16'h0000);
        chk("rst_seen",     seen_q0, 16'h0000);
        chk("rst_out_en0",  out0, 16'h0000);
        chk("rst_out1_en0", out1, 16'hFFFF);
        rst = 1'b0;

        // Sweep all codes
        for (int i = 0; i < 16; i++) begin
            en = 1'b1;
            in = 4'(i);
            exp = 16'h0001 << i;
            #1;
            chk($sformatf("sweep_out_%0d", i), out0, exp);
            chk($sformatf("sweep_out1_%0d", i), out1, ~exp);
            tick();
            chk($sformatf("sweep_out_q_%0d", i), out_q0, exp);
            chk($sformatf("sweep_out_q1_%0d", i), out_q1, ~exp);
            chk($sformatf("sweep_valid_%0d", i), {15'd0, valid_q0}, 16'h0001);
            chk($sformatf("sweep_idx_%0d", i), {12'd0, idx_q0}, 16'(i));
        end
        chk("sweep_seen0", seen_q0, SWEEP_SEEN);
        chk("sweep_seen1", seen_q1, SWEEP_SEEN);

        // Repeat code 9 for two cycles
        in = 4'h9;
        tick();
        chk("rep1_out_q", out_q0, 16'h0200);
        chk("rep1_idx",   {12'd0, idx_q0}, 16'h0009);
        tick();
        chk("rep2_out_q", out_q0, 16'h0200);
        chk("rep2_idx",   {12'd0, idx_q0}, 16'h0009);

        // Enable low
        en = 1'b0;
        in = 4'hF;
        #1;
        chk("en0_out0", out0, 16'h0000);
        chk("en0_out1", out1, 16'hFFFF);
        tick();
        chk("en0_valid",  {15'd0, valid_q0}, 16'h0000);
        chk("en0_idx",    {12'd0, idx_q0}, 16'h0009);
        chk("en0_out_q0", out_q0, 16'h0000);
        chk("en0_out_q1", out_q1, 16'hFFFF);

        // Polarity
        en = 1'b1;
        in = 4'h3;
        #1;
        chk("pol_en1", out1, 16'hFFF7);
        en = 1'b0;
        #1;
        chk("pol_en0", out1, 16'hFFFF);

        // Mid-sequence reset at code 5
        en  = 1'b1;
        in  = 4'h5;
        rst = 1'b1;
        tick();
        chk("mrst_out_q0", out_q0, 16'h0000);
        chk("mrst_out_q1", out_q1, 16'hFFFF);
        chk("mrst_valid",  {15'd0, valid_q0}, 16'h0000);
        chk("mrst_idx",    {12'd0, idx_q0}, 16'h0000);
        chk("mrst_seen",   seen_q0, 16'h0000);
        chk("mrst_out",    out0, 16'h0020);
        rst = 1'b0;
        tick();
        chk("resume_out_q", out_q0, 16'h0020);
        chk("resume_idx",   {12'd0, idx_q0}, 16'h0005);
        chk("resume_valid", {15'd0, valid_q0}, 16'h0001);

        // Seen mask: clear, then decode 1, 4, 15
        en  = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mask_clr", seen_q0, 16'h0000);
        en = 1'b1;
        in = 4'h1;
        tick();
        in = 4'h4;
        tick();
        in = 4'hF;
        tick();
        en = 1'b0;
        tick();
        chk("mask_seen0", seen_q0, MASK_SEEN);
        chk("mask_seen1", seen_q1, MASK_SEEN);
        chk("mask_idx",   {12'd0, idx_q0}, 16'h000F);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
